multi_tonegen: RTL and testbench

MULTI_TONEGEN -- requirements
Module: multi_tonegen

---
 rtl/multi_tonegen.sv | 182 ++++++++++++++++++
 tb/tb_multi_tonegen.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tonegen.sv
// Multi-channel tone generator: per-channel square/noise oscillators on a shared
// prescaler tick, summed into a registered mix and rendered as PWM.
module multi_tonegen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PRESCALE = 25,
  parameter int unsigned VOL_W    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ena,
  input  logic [$clog2(NUM_CH)+1:0]          address,
  input  logic                               write_strobe,
  input  logic [7:0]                         data,
  output logic [VOL_W+$clog2(NUM_CH)-1:0]    mix_out,
  output logic                               signal_out,
  output logic                               tick_out
);

  localparam int unsigned AW = $clog2(NUM_CH) + 2;
  localparam int unsigned MW = VOL_W + $clog2(NUM_CH);
  localparam logic [7:0]  PresLast = 8'(PRESCALE - 1);
  localparam logic [14:0] LfsrSeed = 15'h0001;

  // Register-interface state
  logic             strobe_q;
  logic             wr;
  logic [AW-1:0]    wr_ch;
  logic [1:0]       wr_reg;

  // Prescaler
  logic [7:0]       presc_q, presc_d;
  logic             tick;

  // Per-channel configuration
  logic [11:0]      period_q [NUM_CH];
  logic [11:0]      period_d [NUM_CH];
  logic             en_q     [NUM_CH];
  logic             en_d     [NUM_CH];
  logic             mode_q   [NUM_CH];
  logic             mode_d   [NUM_CH];
  logic [VOL_W-1:0] vol_q    [NUM_CH];
  logic [VOL_W-1:0] vol_d    [NUM_CH];

  // Per-channel oscillator state
  logic [11:0]      cnt_q    [NUM_CH];
  logic [11:0]      cnt_d    [NUM_CH];
  logic             phase_q  [NUM_CH];
  logic             phase_d  [NUM_CH];
  logic [14:0]      lfsr_q   [NUM_CH];
  logic [14:0]      lfsr_d   [NUM_CH];

  logic             live     [NUM_CH];
  logic [VOL_W-1:0] amp      [NUM_CH];

  // Mixer and PWM
  logic [MW-1:0]    mix_sum;
  logic [MW-1:0]    mix_q, mix_d;
  logic [MW-1:0]    pwm_q, pwm_d;
  logic             sig_q, sig_d;

  // A held strobe writes once: only the low-to-high transition counts.
  assign wr     = write_strobe & ~strobe_q;
  assign wr_ch  = address >> 2;
  assign wr_reg = address[1:0];

  assign tick   = ena && (presc_q == PresLast);

  always_comb begin
    presc_d = presc_q;
    if (ena) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end
  end

  // Amplitude depends only on registered state, so a control write takes
  // effect on the mix one cycle after it lands.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      live[c] = en_q[c] && (period_q[c] != 12'd0);
      amp[c]  = '0;
      if (live[c] && (mode_q[c] ? lfsr_q[c][0] : phase_q[c])) begin
        amp[c] = vol_q[c];
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      period_d[c] = period_q[c];
      en_d[c]     = en_q[c];
      mode_d[c]   = mode_q[c];
      vol_d[c]    = vol_q[c];
      cnt_d[c]    = cnt_q[c];
      phase_d[c]  = phase_q[c];
      lfsr_d[c]   = lfsr_q[c];

      // >= rather than == so a period shrunk under the counter reloads at once.
      if (tick && live[c]) begin
        if (cnt_q[c] >= period_q[c] - 12'd1) begin
          cnt_d[c] = 12'd0;
          if (mode_q[c]) begin
            lfsr_d[c] = {lfsr_q[c][13:0], lfsr_q[c][14] ^ lfsr_q[c][13]};
          end else begin
            phase_d[c] = ~phase_q[c];
          end
        end else begin
          cnt_d[c] = cnt_q[c] + 12'd1;
        end
      end

      if (wr && (wr_ch == AW'(c))) begin
        case (wr_reg)
          2'd0: period_d[c][7:0]  = data;
          2'd1: period_d[c][11:8] = data[3:0];
          2'd2: begin
            en_d[c]   = data[7];
            mode_d[c] = data[6];
            vol_d[c]  = data[VOL_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      mix_sum = mix_sum + MW'(amp[c]);
    end
  end

  always_comb begin
    mix_d = mix_q;
    pwm_d = pwm_q;
    sig_d = sig_q;
    if (ena) begin
      mix_d = mix_sum;
      pwm_d = pwm_q + 1'b1;
      sig_d = mix_q > pwm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= 1'b1;
      presc_q  <= '0;
      mix_q    <= '0;
      pwm_q    <= '0;
      sig_q    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        period_q[c] <= '0;
        en_q[c]     <= 1'b0;
        mode_q[c]   <= 1'b0;
        vol_q[c]    <= '0;
        cnt_q[c]    <= '0;
        phase_q[c]  <= 1'b0;
        lfsr_q[c]   <= LfsrSeed;
      end
    end else begin
      strobe_q <= write_strobe;
      presc_q  <= presc_d;
      mix_q    <= mix_d;
      pwm_q    <= pwm_d;
      sig_q    <= sig_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        period_q[c] <= period_d[c];
        en_q[c]     <= en_d[c];
        mode_q[c]   <= mode_d[c];
        vol_q[c]    <= vol_d[c];
        cnt_q[c]    <= cnt_d[c];
        phase_q[c]  <= phase_d[c];
        lfsr_q[c]   <= lfsr_d[c];
      end
    end
  end

  assign mix_out    = mix_q;
  assign signal_out = sig_q;
  assign tick_out   = tick;

endmodule

// File: tb/tb_multi_tonegen.sv
// Bench for multi_tonegen: cycle-level reference model checked every cycle, plus a
// vector table and hand-written sequences with hand-derived expectations.
module tb_multi_tonegen;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 25;
  localparam int VOL_W    = 4;
  localparam int MW       = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [3:0]    address = '0;
  logic          write_strobe = 1'b0;
  logic [7:0]    data = '0;
  logic [MW-1:0] mix_out;
  logic          signal_out;
  logic          tick_out;

  always #5 clk = ~clk;

  multi_tonegen #(
    .NUM_CH   (NUM_CH),
    .PRESCALE (PRESCALE),
    .VOL_W    (VOL_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .address      (address),
    .write_strobe (write_strobe),
    .data         (data),
    .mix_out      (mix_out),
    .signal_out   (signal_out),
    .tick_out     (tick_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: channel state held as plain integers
  int m_per [NUM_CH], m_cnt [NUM_CH], m_vol [NUM_CH], m_lfsr [NUM_CH];
  bit m_en [NUM_CH], m_mode [NUM_CH], m_ph [NUM_CH];
  int m_presc, m_mix, m_pwm;
  bit m_sig, m_sprev;

  function automatic int lfsr_next(input int l);
    return ((l << 1) | (((l >> 14) ^ (l >> 13)) & 1)) & 32'h7fff;
  endfunction

  task automatic model_edge();
    int  sum;
    bit  tk;
    int  ch, rg;
    if (rst) begin
      m_presc = 0; m_mix = 0; m_pwm = 0; m_sig = 0; m_sprev = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_per[c] = 0; m_cnt[c] = 0; m_vol[c] = 0; m_lfsr[c] = 1;
        m_en[c] = 0; m_mode[c] = 0; m_ph[c] = 0;
      end
      return;
    end
    sum = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (m_en[c] && m_per[c] != 0 && (m_mode[c] ? (m_lfsr[c] & 1) == 1 : m_ph[c]))
        sum += m_vol[c];
    tk = ena && (m_presc == PRESCALE - 1);
    if (ena) begin
      m_sig   = m_mix > m_pwm;
      m_mix   = sum;
      m_pwm   = (m_pwm + 1) % (1 << MW);
      m_presc = tk ? 0 : m_presc + 1;
    end
    if (tk) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_en[c] && m_per[c] != 0) begin
          if (m_cnt[c] >= m_per[c] - 1) begin
            m_cnt[c] = 0;
            if (m_mode[c]) m_lfsr[c] = lfsr_next(m_lfsr[c]);
            else m_ph[c] = !m_ph[c];
          end else begin
            m_cnt[c]++;
          end
        end
      end
    end
    if (write_strobe && !m_sprev) begin
      ch = int'(address) / 4;
      rg = int'(address) % 4;
      if (ch < NUM_CH) begin
        if (rg == 0) m_per[ch] = (m_per[ch] & 'hF00) | int'(data);
        else if (rg == 1) m_per[ch] = (m_per[ch] & 'hFF) | ((int'(data) & 'hF) << 8);
        else if (rg == 2) begin
          m_en[ch]   = data[7];
          m_mode[ch] = data[6];
          m_vol[ch]  = int'(data) % (1 << VOL_W);
        end
      end
    end
    m_sprev = write_strobe;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_mix", int'(mix_out), m_mix);
    check("model_sig", int'(signal_out), int'(m_sig));
    check("model_tick", int'(tick_out), int'(ena && m_presc == PRESCALE - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; write_strobe = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    address = a; data = d; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    step();
  endtask

  task automatic wait_mix(input int val, input int budget, input string name);
    int got;
    got = -1;
    for (int i = 0; i < budget; i++) begin
      if (int'(mix_out) == val) begin
        got = val;
        break;
      end
      step();
    end
    check(name, got, val);
  endtask

  // Assumes the current sample is the first of a run at value v.
  task automatic measure_run(input int v, output int len, output int hi);
    len = 1; hi = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (int'(mix_out) != v) break;
      len++;
      if (i < 64) hi += int'(signal_out);
    end
  endtask

  task automatic wait_tick(input string name);
    int found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (tick_out) begin
        found = 1;
        break;
      end
      step();
    end
    check(name, found, 1);
  endtask

  typedef struct {
    bit         en;
    logic [3:0] addr;
    logic [7:0] d;
    int         peak;
  } vec_t;

  vec_t tbl [12];
  int   exp_bits [101];

  initial begin
    int len, hi, pk, n, l;

    tbl[0]  = '{1'b0, 4'd0,  8'h01, 0};
    tbl[1]  = '{1'b0, 4'd4,  8'h01, 0};
    tbl[2]  = '{1'b0, 4'd8,  8'h01, 0};
    tbl[3]  = '{1'b0, 4'd12, 8'h01, 0};
    tbl[4]  = '{1'b0, 4'd2,  8'h8F, 0};
    tbl[5]  = '{1'b0, 4'd6,  8'h8F, 0};
    tbl[6]  = '{1'b0, 4'd10, 8'h8F, 0};
    tbl[7]  = '{1'b0, 4'd14, 8'h8F, 0};
    tbl[8]  = '{1'b1, 4'd3,  8'hFF, 60};
    tbl[9]  = '{1'b1, 4'd10, 8'h00, 45};
    tbl[10] = '{1'b1, 4'd1,  8'hF0, 45};
    tbl[11] = '{1'b1, 4'd6,  8'h83, 33};

    l = 1;
    for (int k = 0; k <= 100; k++) begin
      exp_bits[k] = l & 1;
      l = lfsr_next(l);
    end

    // Reset state
    do_reset();
    check("rst_mix", int'(mix_out), 0);
    check("rst_sig", int'(signal_out), 0);
    check("rst_tick", int'(tick_out), 0);

    // Idle tick cadence
    ena = 1'b1;
    n = 0;
    while (!tick_out && n < 40) begin
      step();
      n++;
    end
    check("first_tick", n, PRESCALE - 1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      step();
      n++;
      while (!tick_out && n < 40) begin
        step();
        n++;
      end
      check("tick_interval", n, PRESCALE);
      check("idle_mix", int'(mix_out), 0);
    end

    // Table: configure four aligned period-1 channels, then modify
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ena = tbl[i].en;
      wr_reg(tbl[i].addr, tbl[i].d);
      step();
      step();
      pk = 0;
      repeat (110) begin
        step();
        if (int'(mix_out) > pk) pk = int'(mix_out);
      end
      check($sformatf("tbl_peak[%0d]", i), pk, tbl[i].peak);
    end

    // ch0 square, period 3, volume 15
    do_reset();
    wr_reg(4'd0, 8'd3);
    wr_reg(4'd2, 8'h8F);
    ena = 1'b1;
    wait_mix(15, 200, "sq_reach_hi");
    measure_run(15, len, hi);
    check("sq_hi_len", len, 75);
    check("sq_duty", hi, 15);
    measure_run(0, len, hi);
    check("sq_lo_len", len, 75);
    check("sq_lo_duty", hi, 0);

    // Held strobe with changing data stores only the first value
    do_reset();
    address = 4'd0;
    write_strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = 8'(5 + i);
      step();
    end
    write_strobe = 1'b0;
    step();
    wr_reg(4'd2, 8'h8F);
    ena = 1'b1;
    wait_mix(15, 400, "hold_reach_hi");
    measure_run(15, len, hi);
    check("hold_len", len, 125);

    // ch1 noise, period 1
    do_reset();
    wr_reg(4'd4, 8'd1);
    wr_reg(4'd6, 8'hCF);
    ena = 1'b1;
    step();
    check("noise_seed", int'(mix_out), 15);
    for (int k = 1; k <= 100; k++) begin
      wait_tick("noise_tick");
      step();
      step();
      check($sformatf("noise_bit[%0d]", k), int'(mix_out), 15 * exp_bits[k]);
    end

    // Reset mid-tone with strobe held through it
    do_reset();
    wr_reg(4'd0, 8'd3);
    wr_reg(4'd2, 8'h8F);
    ena = 1'b1;
    wait_mix(15, 200, "rst_tone_reach");
    address = 4'd2; data = 8'h8F; write_strobe = 1'b1; rst = 1'b1;
    step();
    check("midrst_mix", int'(mix_out), 0);
    check("midrst_sig", int'(signal_out), 0);
    check("midrst_tick", int'(tick_out), 0);
    rst = 1'b0;
    repeat (5) step();
    write_strobe = 1'b0;
    step();
    wr_reg(4'd0, 8'd1);
    pk = 0;
    repeat (100) begin
      step();
      if (int'(mix_out) > pk) pk = int'(mix_out);
    end
    check("midrst_no_write", pk, 0);

    // Randomised traffic against the model
    do_reset();
    ena = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) ena = !ena;
      write_strobe = ($urandom_range(0, 2) == 0);
      address = 4'($urandom_range(0, 15));
      case (address[1:0])
        2'd0: data = 8'($urandom_range(0, 6));
        2'd1: data = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom & 32'hF0);
        default: data = 8'($urandom);
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
